fifo_wr_arbiter: RTL

Round-robin arbiter sharing the write port of the dual-clock FIFO among `NUM_REQ` producers in the write clock domain. It grants one requester at a time for a burst, ended by a last-flag or a burst cap. It muxes the owner's data onto the FIFO write port and stalls on the FIFO's `full` flag. It sits directly in front of the FIFO write side and runs entirely on `wclk`.

---
 rtl/fifo_wr_arbiter_pkg.sv | 24 ++
 rtl/fifo_wr_arbiter_picker.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding and width helpers.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Beat counter must be able to hold MAX_BURST itself.
    function automatic int unsigned cnt_width(input int unsigned max_burst);
        if (max_burst < 1) begin
            return 1;
        end
        return int'($clog2(max_burst + 1));
    endfunction

    function automatic int unsigned idx_width(input int unsigned num_req);
        if (num_req < 2) begin
            return 1;
        end
        return int'($clog2(num_req));
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Rotating-priority encoder: first set request at or above rr_ptr, wrapping at NUM_REQ.
module rr_picker
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    localparam logic [IDX_W:0] NUM_REQ_EXT = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0] w_cand;

    // Explicit compare-and-subtract wrap keeps non-power-of-two counts in range.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (w_cand >= NUM_REQ_EXT) begin
                w_cand = w_cand - NUM_REQ_EXT;
            end
            if (!found && req[w_cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers on wclk.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned MAX_BURST  = 4,
    localparam int unsigned IDX_W      = idx_width(NUM_REQ)
)(
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [IDX_W-1:0]              owner,
    output logic                          busy
);

    localparam int unsigned      CNT_W    = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic             w_grant;
    logic             w_own_req;
    logic             w_accept;
    logic             w_release;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .idx    (w_pick)
    );

    // Accept/release decisions for the current owner.
    always_comb begin
        w_grant   = (r_state == ST_GRANT);
        w_own_req = req[r_owner];
        w_accept  = w_grant && w_own_req && !fifo_full;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        w_release = w_grant &&
                    (!w_own_req ||
                     (w_accept && (req_last[r_owner] || (w_cnt_nxt == CNT_MAX))));
        w_ptr_nxt = (r_owner == LAST_IDX) ? '0 : r_owner + IDX_W'(1);
    end

    // Write-port mux; combinational so the FIFO samples it on the next wclk edge.
    always_comb begin
        ack       = '0;
        fifo_w_en = w_accept;
        fifo_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                ack[i] = w_accept;
                if (w_grant) begin
                    fifo_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign owner = r_owner;
    assign busy  = w_grant;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_cnt   <= '0;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_nxt;
                    end
                    // Releasing owner drops to lowest priority for the next pick.
                    if (w_release) begin
                        r_rr_ptr <= w_ptr_nxt;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
